mips_regfile_mp: RTL and testbench
==================================

# mips_regfile_mp

Parametrised multi-port general-purpose register file for the MIPS datapath, the successor to the single-write, dual-read register file. Adds a second write port for load writeback, per-register pending (scoreboard) bits for outstanding loads, and a sequenced bulk-clear engine. Sits between decode (reads, reservations) and the two writeback paths (ALU and memory).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (1..4)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr0_en  in  1  ALU writeback enable
- wr0_addr  in  ADDR_W  ALU writeback address
- wr0_data  in  DATA_W  ALU writeback data
- wr1_en  in  1  load writeback enable
- wr1_addr  in  ADDR_W  load writeback address
- wr1_data  in  DATA_W  load writeback data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  pending bit of the register addressed by port k
- rsv_en  in  1  reserve register (mark pending) for an issued load
- rsv_addr  in  ADDR_W  register to reserve
- clr_req  in  1  start bulk clear sequence
- busy  out  1  bulk clear in progress

## Operation
- Register 0: reads 0, never pending; writes and reservations to address 0 ignored.
- Writes commit on rising clk. wr0 and wr1 to the same nonzero address in one cycle: wr0 data wins.
- Pending bits: rsv_en sets pend[rsv_addr]; wr1_en clears pend[wr1_addr]; wr0 does not affect pending. rsv and wr1 to the same address in one cycle: bit ends set (new reservation wins).
- Reads combinational: rd_data/rd_pend reflect array state, independently per port.
- Bulk clear FSM, states IDLE, SWEEP:
  - IDLE: clr_req=1 -> SWEEP, pointer = 1.
  - SWEEP: each cycle zeroes data and pending of reg[pointer], pointer increments; at pointer = DEPTH-1 the clear completes and FSM returns to IDLE.
  - During SWEEP: wr0, wr1, rsv ignored; clr_req ignored.
- Reset (rst_n low, any time including mid-SWEEP): all registers 0, all pending 0, FSM IDLE, pointer 1, busy 0 — immediately, not waiting for clk.

## Timing
- Write/reservation latency: 1 cycle; visible on rd_data/rd_pend after the capturing edge (see Configuration for same-cycle bypass).
- busy: registered; rises on the edge that samples clr_req in IDLE, falls on the edge that clears reg[DEPTH-1]; high for exactly DEPTH-1 cycles (31 at default).
- Write asserted on the edge busy rises is ignored; write on the edge busy falls is ignored; first accepted write is the following edge.
- Reads during SWEEP return current contents (partially cleared array).
- Reset values: rd_data = 0 all ports, rd_pend = 0, busy = 0.

## Configuration
- MIPS_REGFILE_BYPASS_EN defined: read ports forward same-cycle write data combinationally — if wr0_en (or wr1_en) targets the read address (nonzero, not busy), rd_data returns that write data, wr0 priority over wr1; rd_pend for that port reads 0 when wr1 targets it and rsv does not. Prior-cycle behaviour unchanged.
- Undefined: no forwarding; rd_data/rd_pend show stored state only, new value visible the cycle after the write.

## Test plan
- Reset then read all 32 addresses on both ports -> all 0, rd_pend 0, busy 0.
- wr0 reg5=0xDEADBEEF and wr1 reg5=0x12345678 same cycle -> next cycle reg5 reads 0xDEADBEEF; write 0xFFFFFFFF to reg0 -> reads 0.
- rsv reg9, wait 3 cycles, wr1 reg9=0xA5A5A5A5 -> rd_pend[9] 1 for 3 cycles then 0, data 0xA5A5A5A5; simultaneous rsv+wr1 reg9 -> pend 1.
- Fill regs 1..31 with index value, pulse clr_req -> busy high 31 cycles; mid-sweep reg20 still 20, reg2 0; wr0 reg3=7 during busy ignored; after busy falls all 0.
- Assert rst_n low at sweep cycle 10, no clk edge -> busy 0 and all outputs 0 immediately; clr_req after release restarts at reg1.
- With MIPS_REGFILE_BYPASS_EN: wr0 reg7=0x55 while rd_addr port1=7 -> rd_data port1 = 0x55 same cycle; without macro -> old value, 0x55 next cycle.

Source files
------------

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: two write ports, per-register load-pending bits, bulk-clear sweep.
// Optional same-cycle read forwarding is enabled by defining MIPS_REGFILE_BYPASS_EN.
module mips_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic                wr_ok;
  logic [DATA_W-1:0]   data_arr [DEPTH];
  logic [DEPTH-1:0]    pend_vec;

  // Updates are also dropped on the edge that launches a sweep.
  assign wr_ok = (state_reg == IDLE) && !clr_req;
  assign busy  = (state_reg == SWEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= ADDR_W'(1);
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = SWEEP;
          ptr_next   = ADDR_W'(1);
        end
      end
      SWEEP: begin
        if (ptr_reg == LAST) begin
          state_next = IDLE;
          ptr_next   = ADDR_W'(1);
        end else begin
          ptr_next = ptr_reg + ADDR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = ADDR_W'(1);
      end
    endcase
  end

  assign data_arr[0] = '0;
  assign pend_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] data_reg;
      logic              pend_reg;
      logic              sweep_hit, wr0_hit, wr1_hit, rsv_hit;

      assign sweep_hit = busy && (ptr_reg == ADDR_W'(gi));
      assign wr0_hit   = wr_ok && wr0_en && (wr0_addr == ADDR_W'(gi));
      assign wr1_hit   = wr_ok && wr1_en && (wr1_addr == ADDR_W'(gi));
      assign rsv_hit   = wr_ok && rsv_en && (rsv_addr == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          pend_reg <= 1'b0;
        end else if (sweep_hit) begin
          data_reg <= '0;
          pend_reg <= 1'b0;
        end else begin
          if (wr0_hit)      data_reg <= wr0_data;
          else if (wr1_hit) data_reg <= wr1_data;
          // A fresh reservation outranks the load that retires in the same cycle.
          if (rsv_hit)      pend_reg <= 1'b1;
          else if (wr1_hit) pend_reg <= 1'b0;
        end
      end

      assign data_arr[gi] = data_reg;
      assign pend_vec[gi] = pend_reg;
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] port_data;
      logic              port_pend;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

`ifdef MIPS_REGFILE_BYPASS_EN
      logic fwd0, fwd1, rsv_same;
      assign fwd0     = wr_ok && wr0_en && (wr0_addr == addr) && (addr != '0);
      assign fwd1     = wr_ok && wr1_en && (wr1_addr == addr) && (addr != '0);
      assign rsv_same = rsv_en && (rsv_addr == addr);

      always_comb begin
        port_data = data_arr[addr];
        port_pend = pend_vec[addr];
        if (fwd0)      port_data = wr0_data;
        else if (fwd1) port_data = wr1_data;
        if (fwd1 && !rsv_same) port_pend = 1'b0;
      end
`else
      assign port_data = data_arr[addr];
      assign port_pend = pend_vec[addr];
`endif

      assign rd_data[gi*DATA_W +: DATA_W] = port_data;
      assign rd_pend[gi]                  = port_pend;
    end
  endgenerate

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench for mips_regfile_mp: array-level reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mips_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wr0_en = 1'b0, wr1_en = 1'b0, rsv_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wr0_addr = '0, wr1_addr = '0, rsv_addr = '0;
  logic [DW-1:0] wr0_data = '0, wr1_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pend;
  logic             busy;

  int checks = 0;
  int passes = 0;

  mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Reference model: register contents, pending flags, and the set of registers still to be cleared.
  bit [31:0] m_data [32];
  bit        m_pend [32];
  bit        m_todo [32];

  function automatic bit any_todo();
    for (int i = 0; i < 32; i++) if (m_todo[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_todo();
    for (int i = 0; i < 32; i++) if (m_todo[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] <= 0; m_pend[i] <= 0; m_todo[i] <= 0;
      end
    end else if (any_todo()) begin
      m_data[first_todo()] <= 0;
      m_pend[first_todo()] <= 0;
      m_todo[first_todo()] <= 0;
    end else if (clr_req) begin
      for (int i = 1; i < 32; i++) m_todo[i] <= 1;
    end else begin
      if (wr1_en && wr1_addr != 0) begin
        m_data[wr1_addr] <= wr1_data;
        m_pend[wr1_addr] <= 0;
      end
      if (wr0_en && wr0_addr != 0) m_data[wr0_addr] <= wr0_data;
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] <= 1;
    end
  end

  function automatic logic [31:0] exp_data(input int a);
    if (a == 0) return 0;
`ifdef MIPS_REGFILE_BYPASS_EN
    if (!any_todo() && !clr_req) begin
      if (wr0_en && wr0_addr == a) return wr0_data;
      if (wr1_en && wr1_addr == a) return wr1_data;
    end
`endif
    return m_data[a];
  endfunction

  function automatic logic exp_pend(input int a);
    if (a == 0) return 0;
`ifdef MIPS_REGFILE_BYPASS_EN
    if (!any_todo() && !clr_req && wr1_en && wr1_addr == a && !(rsv_en && rsv_addr == a)) return 0;
`endif
    return m_pend[a];
  endfunction

  always @(negedge clk) begin
    check("cmp_busy", {31'd0, busy}, {31'd0, any_todo()});
    for (int k = 0; k < NR; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      check($sformatf("cmp_data%0d_r%0d", k, a), rd_data[k*DW +: DW], exp_data(a));
      check($sformatf("cmp_pend%0d_r%0d", k, a), {31'd0, rd_pend[k]}, {31'd0, exp_pend(a)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr1_en = 0; rsv_en = 0; clr_req = 0;
  endtask

  initial begin
    int cnt;

    // Reset: every address reads zero on both ports, nothing pending, not busy.
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      check("rst_data0", rd_data[31:0], 32'h0);
      check("rst_data1", rd_data[63:32], 32'h0);
      check("rst_pend", {30'd0, rd_pend}, 32'h0);
    end
    check("rst_busy", {31'd0, busy}, 32'h0);
    cyc();
    rst_n = 1;
    cyc();

    // Write collision: wr0 wins; register 0 stays zero.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h12345678;
    cyc();
    idle_inputs();
    set_rd(5, 0);
    check("collide_r5", rd_data[31:0], 32'hDEADBEEF);
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    cyc();
    idle_inputs();
    check("r0_zero", rd_data[63:32], 32'h0);
    rsv_en = 1; rsv_addr = 0;
    cyc();
    idle_inputs();
    check("r0_never_pend", {31'd0, rd_pend[1]}, 32'h0);

    // Reservation held until the load returns.
    rsv_en = 1; rsv_addr = 9;
    cyc();
    idle_inputs();
    set_rd(0, 9);
    for (int i = 0; i < 3; i++) begin
      check("rsv_pend_hold", {31'd0, rd_pend[1]}, 32'h1);
      if (i == 2) begin
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'hA5A5A5A5;
      end
      cyc();
    end
    idle_inputs();
    check("wr1_clears_pend", {31'd0, rd_pend[1]}, 32'h0);
    check("wr1_data_r9", rd_data[63:32], 32'hA5A5A5A5);
    rsv_en = 1; rsv_addr = 9; wr1_en = 1; wr1_addr = 9; wr1_data = 32'h1;
    cyc();
    idle_inputs();
    check("rsv_beats_wr1", {31'd0, rd_pend[1]}, 32'h1);
    check("rsv_wr1_data", rd_data[63:32], 32'h1);

    // Fill with index values, then sweep.
    for (int i = 1; i < 32; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = i;
      cyc();
    end
    idle_inputs();
    clr_req = 1;
    cyc();
    clr_req = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin
        set_rd(2, 20);
        check("mid_sweep_r2", rd_data[31:0], 32'h0);
        check("mid_sweep_r20", rd_data[63:32], 32'd20);
      end
      if (cnt == 10) begin
        wr0_en = 1; wr0_addr = 3; wr0_data = 7;
      end
      if (cnt == 31) begin
        wr0_en = 1; wr0_addr = 4; wr0_data = 9;
      end
      cyc();
      wr0_en = 0;
    end
    check("busy_cycles", cnt, 32'd31);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, a);
      check("post_sweep_data", rd_data[31:0], 32'h0);
      check("post_sweep_pend", {31'd0, rd_pend[0]}, 32'h0);
    end
    wr0_en = 1; wr0_addr = 6; wr0_data = 6;
    cyc();
    idle_inputs();
    set_rd(6, 3);
    check("first_write_after", rd_data[31:0], 32'd6);
    check("sweep_write_ignored", rd_data[63:32], 32'h0);

    // Asynchronous reset in the middle of a sweep.
    wr0_en = 1; wr0_addr = 30; wr0_data = 30; rsv_en = 1; rsv_addr = 30;
    cyc();
    idle_inputs();
    clr_req = 1;
    cyc();
    clr_req = 0;
    for (int i = 0; i < 9; i++) cyc();
    set_rd(30, 30);
    check("pre_rst_r30", rd_data[31:0], 32'd30);
    #1;
    rst_n = 0;
    #1;
    check("async_busy", {31'd0, busy}, 32'h0);
    check("async_data0", rd_data[31:0], 32'h0);
    check("async_data1", rd_data[63:32], 32'h0);
    check("async_pend", {30'd0, rd_pend}, 32'h0);
    cyc();
    rst_n = 1;
    wr0_en = 1; wr0_addr = 1; wr0_data = 11; wr1_en = 1; wr1_addr = 2; wr1_data = 22;
    cyc();
    idle_inputs();
    clr_req = 1;
    cyc();
    clr_req = 0;
    check("restart_busy", {31'd0, busy}, 32'h1);
    cyc();
    set_rd(1, 2);
    check("restart_r1", rd_data[31:0], 32'h0);
    check("restart_r2", rd_data[63:32], 32'd22);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      cyc();
    end
    check("restart_done", {31'd0, busy}, 32'h0);

    // Same-cycle forwarding (or its absence).
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
    cyc();
    wr0_data = 32'h55;
    set_rd(0, 7);
`ifdef MIPS_REGFILE_BYPASS_EN
    check("bypass_same_cycle", rd_data[63:32], 32'h55);
`else
    check("no_bypass_old", rd_data[63:32], 32'h11);
`endif
    cyc();
    idle_inputs();
    check("write_next_cycle", rd_data[63:32], 32'h55);
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
